// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory loader and run controller.
package program_loader_pkg;

  localparam int unsigned INSN_WIDTH        = 9;
  localparam int unsigned LOADER_ADDR_W     = 8;
  localparam int unsigned LOADER_CNT_W      = 16;
  localparam int unsigned LOADER_MAX_CYCLES = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } loader_state_t;

  // Host beats are only taken while a program is being gathered.
  function automatic logic state_accepts(loader_state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/program_loader_run_timer.sv
// Run-cycle counter with enable, clear and a terminal-count compare.
module program_loader_run_timer #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TERMINAL = 32'h0000_FFFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             terminal_c_o
);

  localparam int unsigned CW1 = CNT_W + 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High during the cycle whose increment reaches the terminal count.
  assign terminal_c_o = (CW1'(count_q) + CW1'(1)) == CW1'(TERMINAL);
  assign count_o      = count_q;

endmodule

// File: rtl/program_loader.sv
// Streams a program into instruction memory, then runs the core until halt or timeout.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned INSN_W     = INSN_WIDTH,
  parameter int unsigned ADDR_W     = LOADER_ADDR_W,
  parameter int unsigned CNT_W      = LOADER_CNT_W,
  parameter int unsigned MAX_CYCLES = LOADER_MAX_CYCLES
) (
  input  logic              _CLK,
  input  logic              _reset,
  input  logic              _insnValid,
  input  logic [INSN_W-1:0] _insnData,
  input  logic              _insnLast,
  output logic              insnReady,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [INSN_W-1:0] memData,
  output logic              start,
  input  logic              _halt,
  input  logic              _clear,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   loadCount,
  output logic [CNT_W-1:0]  cycleCount
);

  loader_state_t     state_q;
  logic [ADDR_W:0]   load_cnt_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [INSN_W-1:0] mem_data_q;
  logic              start_q;
  logic              done_q;
  logic              timeout_q;
  logic              overflow_q;

  logic              beat_c;
  logic              ptr_full_c;
  logic              run_c;
  logic              timer_clr_c;
  logic              terminal_c;
  logic [CNT_W-1:0]  cycle_cnt;

  assign insnReady   = state_accepts(state_q);
  assign beat_c      = _insnValid & insnReady;
  // The write pointer is the word count; beats only arrive below capacity.
  assign ptr_full_c  = (load_cnt_q[ADDR_W-1:0] == '1);
  assign run_c       = (state_q == ST_RUN);
  assign timer_clr_c = (state_q == ST_DONE) & _clear;

  program_loader_run_timer #(
    .CNT_W   (CNT_W),
    .TERMINAL(MAX_CYCLES)
  ) u_run_timer (
    .clk_i       (_CLK),
    .rst_i       (_reset),
    .en_i        (run_c),
    .clr_i       (timer_clr_c),
    .count_o     (cycle_cnt),
    .terminal_c_o(terminal_c)
  );

  always_ff @(posedge _CLK) begin
    if (_reset) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (beat_c) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= load_cnt_q[ADDR_W-1:0];
            mem_data_q  <= _insnData;
            load_cnt_q  <= load_cnt_q + (ADDR_W+1)'(1);
            if (_insnLast) begin
              state_q <= ST_ARM;
            end else if (ptr_full_c) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              overflow_q <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_ARM: begin
          state_q <= ST_RUN;
          start_q <= 1'b1;
        end
        ST_RUN: begin
          // Halt takes precedence over a coincident timeout.
          if (_halt) begin
            state_q <= ST_DONE;
            start_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (terminal_c) begin
            state_q   <= ST_DONE;
            start_q   <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (_clear) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign memWrite   = mem_write_q;
  assign memAddr    = mem_addr_q;
  assign memData    = mem_data_q;
  assign start      = start_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;
  assign loadCount  = load_cnt_q;
  assign cycleCount = cycle_cnt;

endmodule
